// File: rtl/muldiv_unit_pkg.sv
// md_defines: shared definitions for the iterative RV32M multiply/divide unit.
//   md_op_e     - funct3 operation encodings (MD_MUL .. MD_REMU)
//   md_state_e  - sequencer states
//   MD_ZERO_REG - register index driven on rd_waddr_o when no result is valid
package md_defines;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_DONE
  } md_state_e;

  localparam int unsigned MD_ZERO_REG = 0;

endpackage

// File: rtl/muldiv_unit_step.sv
// md_step: one combinational iteration shared by multiply and divide.
//   div_i  - 1: restoring-divide step, 0: shift-add multiply step
//   hi_i   - upper accumulator / partial remainder (DATA_W+1 bits)
//   lo_i   - lower accumulator: multiplier bits or dividend/quotient bits
//   opnd_i - multiplicand (multiply) or divisor (divide) magnitude
//   hi_o, lo_o - accumulator after this iteration
module md_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              div_i,
  input  logic [DATA_W:0]   hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic [DATA_W-1:0] opnd_i,
  output logic [DATA_W:0]   hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W:0]   a;
  logic [DATA_W:0]   b;
  logic [DATA_W+1:0] s;

  // One adder serves both modes: divide computes a - opnd as a + ~opnd + 1,
  // and the carry out of bit DATA_W+1 is the "no borrow" quotient bit.
  always_comb begin
    if (div_i) begin
      a = {hi_i[DATA_W-1:0], lo_i[DATA_W-1]};
      b = ~{1'b0, opnd_i};
    end else begin
      a = hi_i;
      b = lo_i[0] ? {1'b0, opnd_i} : '0;
    end
    s = {1'b0, a} + {1'b0, b} + {{(DATA_W+1){1'b0}}, div_i};
    if (div_i) begin
      hi_o = s[DATA_W+1] ? s[DATA_W:0] : a;
      lo_o = {lo_i[DATA_W-2:0], s[DATA_W+1]};
    end else begin
      hi_o = s[DATA_W+1:1];
      lo_o = {s[0], lo_i[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one result bit per cycle.
//   clk, rst        - clock, synchronous active-high reset
//   start_i, op_i   - request and funct3 operation
//   rs1_rdata       - dividend / multiplicand
//   rs2_rdata       - divisor / multiplier
//   rd_waddr        - destination register
//   flush_i         - abort in-flight operation
//   hold_o          - PC stall request
//   done_o          - one-cycle result-valid pulse
//   rd_waddr_o      - destination register (zero register when idle)
//   rd_wdata_o      - result (zero when idle)
module muldiv_unit
  import md_defines::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] rs1_rdata,
  input  logic [DATA_W-1:0] rs2_rdata,
  input  logic [REG_AW-1:0] rd_waddr,
  input  logic              flush_i,
  output logic              hold_o,
  output logic              done_o,
  output logic [REG_AW-1:0] rd_waddr_o,
  output logic [DATA_W-1:0] rd_wdata_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  md_state_e         state_q;
  md_op_e            op_q;
  logic [REG_AW-1:0] rd_q;
  logic              neg_q;
  logic [DATA_W-1:0] opnd_q;
  logic [DATA_W:0]   hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              done_q;
  logic [REG_AW-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

  md_op_e              op_in;
  logic                accept;
  logic                sgn1, sgn2, is_div_in, is_rem_in, neg_in, div0, ovf;
  logic [DATA_W-1:0]   abs1, abs2, fast_res, calc_res;
  logic [DATA_W:0]     step_hi;
  logic [DATA_W-1:0]   step_lo;
  logic [2*DATA_W-1:0] prod, prod_s;
  logic [DATA_W-1:0]   quo_s, rem_s;

  assign op_in  = md_op_e'(op_i);
  assign accept = start_i & ~flush_i & ~rst &
                  ((state_q == MD_IDLE) | (state_q == MD_DONE));

  always_comb begin
    sgn1      = rs1_rdata[DATA_W-1] &
                (op_in inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    sgn2      = rs2_rdata[DATA_W-1] & (op_in inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
    abs1      = sgn1 ? -rs1_rdata : rs1_rdata;
    abs2      = sgn2 ? -rs2_rdata : rs2_rdata;
    is_div_in = op_i[2];
    is_rem_in = op_i[2] & op_i[1];
    neg_in    = is_rem_in ? sgn1 : (sgn1 ^ sgn2);
    div0      = is_div_in & (rs2_rdata == '0);
    ovf       = (op_in inside {MD_DIV, MD_REM}) &
                (rs1_rdata == {1'b1, {(DATA_W-1){1'b0}}}) & (rs2_rdata == '1);
    if (div0) fast_res = is_rem_in ? rs1_rdata : '1;
    else      fast_res = is_rem_in ? '0 : rs1_rdata;
  end

  md_step #(.DATA_W(DATA_W)) u_step (
    .div_i  (op_q[2]),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .opnd_i (opnd_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  // Sign correction is applied to the final step output so the corrected
  // result lands in the output register on the last CALC cycle.
  always_comb begin
    prod   = {step_hi[DATA_W-1:0], step_lo};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -step_lo : step_lo;
    rem_s  = neg_q ? -step_hi[DATA_W-1:0] : step_hi[DATA_W-1:0];
    case (op_q)
      MD_MUL:                       calc_res = prod_s[DATA_W-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: calc_res = prod_s[2*DATA_W-1:DATA_W];
      MD_DIV, MD_DIVU:              calc_res = quo_s;
      default:                      calc_res = rem_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      op_q    <= MD_MUL;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      waddr_q <= REG_AW'(MD_ZERO_REG);
      wdata_q <= '0;
    end else begin
      done_q  <= 1'b0;
      waddr_q <= REG_AW'(MD_ZERO_REG);
      wdata_q <= '0;
      if (flush_i) begin
        state_q <= MD_IDLE;
      end else begin
        case (state_q)
          MD_CALC: begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              state_q <= MD_DONE;
              done_q  <= 1'b1;
              waddr_q <= rd_q;
              wdata_q <= calc_res;
            end
          end
          default: begin
            if (accept) begin
              op_q   <= op_in;
              rd_q   <= rd_waddr;
              neg_q  <= neg_in;
              opnd_q <= is_div_in ? abs2 : abs1;
              lo_q   <= is_div_in ? abs1 : abs2;
              hi_q   <= '0;
              cnt_q  <= CNT_W'(DATA_W);
              if (div0 | ovf) begin
                state_q <= MD_DONE;
                done_q  <= 1'b1;
                waddr_q <= rd_waddr;
                wdata_q <= fast_res;
              end else begin
                state_q <= MD_CALC;
              end
            end else begin
              state_q <= MD_IDLE;
            end
          end
        endcase
      end
    end
  end

  assign hold_o     = accept | (state_q == MD_CALC);
  assign done_o     = done_q;
  assign rd_waddr_o = waddr_q;
  assign rd_wdata_o = wdata_q;

endmodule
